bf_loop_ctrl: RTL and testbench
===============================

Name: bf_loop_ctrl

Overview:
- Sequences the loop-address stack for the BF core: handles `[` and `]` instructions from the decode stage.
- On `[` it pushes the return address; on `]` it either jumps back or pops.
- On `[` with a zero cell it scans forward past the matching `]` using a nesting counter.
- Drives the external stack's `pushd`/`push_en`/`pop_en` and reads its `top`; tracks stack depth for overflow and underflow detection.

Parameters:
- PC_WIDTH, 8, width of instruction addresses; equals the stack DATA_WIDTH.
- STACK_AW, 5, stack address width; maximum loop depth = 2^STACK_AW.
- SKIP_W, 8, width of the forward-skip nesting counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  decode presents an instruction this cycle.
- op_ready  out  1  controller accepts the instruction; accept = op_valid & op_ready.
- op_open  in  1  instruction is `[`.
- op_close  in  1  instruction is `]`.
- pc  in  PC_WIDTH  address of the presented instruction.
- cell_zero  in  1  current data cell == 0, valid with op_valid.
- stk_top  in  PC_WIDTH  stack top value.
- stk_pushd  out  PC_WIDTH  data to push.
- stk_push  out  1  stack push_en.
- stk_pop  out  1  stack pop_en.
- jump  out  1  one-cycle pulse: fetch must redirect to jump_addr.
- jump_addr  out  PC_WIDTH  redirect target, valid while jump=1.
- skipping  out  1  high while in SKIP.
- depth  out  STACK_AW+1  number of live stack entries.
- err  out  1  sticky error flag.

Behaviour:
- Reset values: state=RUN, depth=0, nest=0, jump=0, jump_addr=0, err=0, skipping=0; stk_push/stk_pop low.
- The stack itself has no reset; the controller tracks depth relative to the stack and never reads entries beyond it.
- States: RUN, SKIP, ERR.
- op_ready = 1 in RUN and SKIP, 0 in ERR.
- stk_push and stk_pop are combinational from the accept cycle, so the stack updates on the same edge. stk_pushd = pc + 1, modulo 2^PC_WIDTH.
- At most one of stk_push or stk_pop is asserted in any cycle.
- RUN, accept `[`, cell_zero=0, depth < 2^STACK_AW: stk_push=1, depth+1.
- RUN, accept `[`, cell_zero=0, depth = 2^STACK_AW: no push; err<=1; go to ERR.
- RUN, accept `[`, cell_zero=1: no stack op; nest<=0; go to SKIP.
- RUN, accept `]`, depth=0: underflow; no stack op; err<=1; go to ERR.
- RUN, accept `]`, cell_zero=0: no stack op; next cycle jump=1 and jump_addr=stk_top sampled at the accept edge. Stack is unchanged.
- RUN, accept `]`, cell_zero=1: stk_pop=1, depth-1, no jump.
- Stack-top hazard: none. The stack updates top on the accept edge, so back-to-back `[` then `]` (or `]` pop then `]`) read the correct top with no stall.
- SKIP: cell_zero is ignored and no stack ops are issued.
  - Accept `[`: nest+1. If nest = 2^SKIP_W-1, set err and go to ERR instead.
  - Accept `]` with nest>0: nest-1.
  - Accept `]` with nest=0: return to RUN; the next instruction is the one after the matching `]`.
- Any state, op_open & op_close both high: instruction consumed as a no-op; no state change.
- Other instructions (both low) are accepted as no-ops in every state except ERR.
- jump is asserted only the cycle after an accepted `]` and is never asserted in SKIP or ERR.
- The fetch unit flushes on jump; any instruction accepted in the same cycle jump is high is still processed, so fetch must hold op_valid low that cycle.
- ERR: sticky until rst; op_ready=0; no stack ops; no jumps.
- rst in any state (including mid-SKIP or the cycle of a pending jump) overrides all else: jump cleared, state RUN, depth 0.

Test Plan:
- Simple loop: `[` at pc=3 with cell_zero=0 → stk_push=1, stk_pushd=4, depth=1. Then `]` at pc=9 with cell_zero=0 → jump=1 next cycle, jump_addr=4. Then `]` with cell_zero=1 → stk_pop=1, depth=0, no jump.
- Skip nested: `[` (cell_zero=1) at pc=2, then stream `[`, `]`, `]` → skipping=1 for those cycles, nest 1→0, then RUN after the third op. No stk_push/stk_pop, no jump, depth unchanged.
- Overflow: STACK_AW=2, five `[` with cell_zero=0 → four pushes with depth reaching 4. The fifth raises err=1, op_ready=0, no push. Further ops are not accepted.
- Underflow: after reset, `]` with cell_zero=1 → err=1, stk_pop=0, state ERR.
- Back-to-back: `[` at pc=10, next cycle `]` with cell_zero=0 → jump_addr=11 with no stall; op_ready stays 1.
- Reset mid-skip: enter SKIP with nest=3, assert rst for one cycle → skipping=0, depth=0, err=0. Next `[` with cell_zero=0 pushes normally.

Source files
------------

// File: rtl/bf_loop_ctrl_if.sv
// Decode/stack-side bundle for the BF loop controller.
// The master is the fetch/decode stage plus the external loop stack; the slave is the controller.
interface bf_loop_ctrl_if #(
  parameter int PC_WIDTH = 8,
  parameter int STACK_AW = 5
);
  logic                op_valid;
  logic                op_ready;
  logic                op_open;
  logic                op_close;
  logic [PC_WIDTH-1:0] pc;
  logic                cell_zero;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] stk_pushd;
  logic                stk_push;
  logic                stk_pop;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_addr;
  logic                skipping;
  logic [STACK_AW:0]   depth;
  logic                err;

  modport master (
    output op_valid, op_open, op_close, pc, cell_zero, stk_top,
    input  op_ready, stk_pushd, stk_push, stk_pop, jump, jump_addr,
           skipping, depth, err
  );

  modport slave (
    input  op_valid, op_open, op_close, pc, cell_zero, stk_top,
    output op_ready, stk_pushd, stk_push, stk_pop, jump, jump_addr,
           skipping, depth, err
  );
endinterface

// File: rtl/bf_loop_ctrl.sv
// Loop controller for the BF core: handles `[` / `]`, drives the external loop stack,
// skips forward over zero-cell loops and latches a sticky error on stack/nest overflow or underflow.
module bf_loop_ctrl #(
  parameter int PC_WIDTH = 8,
  parameter int STACK_AW = 5,
  parameter int SKIP_W   = 8
) (
  input logic            clk,
  input logic            rst,
  bf_loop_ctrl_if.slave  bus
);
  localparam int DW = STACK_AW + 1;
  localparam logic [STACK_AW:0] DEPTH_FULL = {1'b1, {STACK_AW{1'b0}}};

  typedef enum logic [1:0] {RUN, SKIP, ERR} state_t;

  state_t              state_q, state_d;
  logic [STACK_AW:0]   depth_q, depth_d;
  logic [SKIP_W-1:0]   nest_q, nest_d;
  logic                jump_q, jump_d;
  logic [PC_WIDTH-1:0] jump_addr_q, jump_addr_d;
  logic                do_push, do_pop;
  logic                accept, is_open, is_close;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      depth_q     <= '0;
      nest_q      <= '0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      nest_q      <= nest_d;
      jump_q      <= jump_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  // Both opcode bits high decodes as a no-op, so only exclusive opens/closes act.
  always_comb begin
    accept      = bus.op_valid & bus.op_ready;
    is_open     = accept & bus.op_open & ~bus.op_close;
    is_close    = accept & bus.op_close & ~bus.op_open;
    state_d     = state_q;
    depth_d     = depth_q;
    nest_d      = nest_q;
    jump_d      = 1'b0;
    jump_addr_d = jump_addr_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (is_open) begin
          if (bus.cell_zero) begin
            nest_d  = '0;
            state_d = SKIP;
          end else if (depth_q == DEPTH_FULL) begin
            state_d = ERR;
          end else begin
            do_push = 1'b1;
            depth_d = depth_q + DW'(1);
          end
        end else if (is_close) begin
          if (depth_q == '0) begin
            state_d = ERR;
          end else if (!bus.cell_zero) begin
            jump_d      = 1'b1;
            jump_addr_d = bus.stk_top;
          end else begin
            do_pop  = 1'b1;
            depth_d = depth_q - DW'(1);
          end
        end
      end
      SKIP: begin
        if (is_open) begin
          if (&nest_q) state_d = ERR;
          else         nest_d  = nest_q + SKIP_W'(1);
        end else if (is_close) begin
          if (nest_q != '0) nest_d  = nest_q - SKIP_W'(1);
          else              state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  // Stack strobes are gated by rst so a reset cycle never disturbs the stack.
  always_comb begin
    bus.op_ready  = (state_q != ERR);
    bus.skipping  = (state_q == SKIP);
    bus.err       = (state_q == ERR);
    bus.depth     = depth_q;
    bus.jump      = jump_q;
    bus.jump_addr = jump_addr_q;
    bus.stk_pushd = bus.pc + PC_WIDTH'(1);
    bus.stk_push  = do_push & ~rst;
    bus.stk_pop   = do_pop & ~rst;
  end
endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Self-checking bench for bf_loop_ctrl: directed loop scenarios followed by random opcode streams,
// compared against a queue-based model of the loop stack and skip nesting.
module tb_bf_loop_ctrl;
  localparam int PW        = 8;
  localparam int AW        = 2;
  localparam int SW        = 3;
  localparam int STACK_MAX = 1 << AW;
  localparam int NEST_MAX  = (1 << SW) - 1;
  localparam int M_RUN     = 0;
  localparam int M_SKIP    = 1;
  localparam int M_ERR     = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bf_loop_ctrl_if #(.PC_WIDTH(PW), .STACK_AW(AW)) bus ();

  bf_loop_ctrl #(.PC_WIDTH(PW), .STACK_AW(AW), .SKIP_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External loop stack, driven only by the controller's strobes.
  logic [PW-1:0] env_mem [STACK_MAX];
  int            env_sp = 0;

  always @(posedge clk) begin
    if (rst) begin
      env_sp <= 0;
    end else if (bus.stk_push && env_sp < STACK_MAX) begin
      env_mem[env_sp] <= bus.stk_pushd;
      env_sp          <= env_sp + 1;
    end else if (bus.stk_pop && env_sp > 0) begin
      env_sp <= env_sp - 1;
    end
  end

  assign bus.stk_top = (env_sp > 0) ? env_mem[env_sp-1] : '0;

  int            vectors     = 0;
  int            miscompares = 0;
  int            m_mode      = M_RUN;
  int            m_nest      = 0;
  logic [PW-1:0] m_stk[$];
  logic          m_jump      = 1'b0;
  logic [PW-1:0] m_jaddr     = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic o, input logic c,
                               input logic [PW-1:0] p, input logic cz);
    logic          acc, op_o, op_c, exp_push, exp_pop;
    logic [PW-1:0] nxt;
    @(negedge clk);
    rst           = r;
    bus.op_valid  = v;
    bus.op_open   = o;
    bus.op_close  = c;
    bus.pc        = p;
    bus.cell_zero = cz;
    #1;
    nxt      = p + 8'd1;
    acc      = v && (m_mode != M_ERR);
    op_o     = o && !c;
    op_c     = c && !o;
    exp_push = !r && acc && m_mode == M_RUN && op_o && !cz && m_stk.size() < STACK_MAX;
    exp_pop  = !r && acc && m_mode == M_RUN && op_c && cz && m_stk.size() > 0;
    checkOutput("op_ready", {31'd0, bus.op_ready}, {31'd0, m_mode != M_ERR});
    checkOutput("stk_push", {31'd0, bus.stk_push}, {31'd0, exp_push});
    checkOutput("stk_pop", {31'd0, bus.stk_pop}, {31'd0, exp_pop});
    if (exp_push) checkOutput("stk_pushd", {24'd0, bus.stk_pushd}, {24'd0, nxt});

    m_jump = 1'b0;
    if (r) begin
      m_mode  = M_RUN;
      m_nest  = 0;
      m_jaddr = '0;
      m_stk.delete();
    end else if (acc && m_mode == M_RUN) begin
      if (op_o) begin
        if (cz) begin
          m_mode = M_SKIP;
          m_nest = 0;
        end else if (m_stk.size() == STACK_MAX) m_mode = M_ERR;
        else m_stk.push_back(nxt);
      end else if (op_c) begin
        if (m_stk.size() == 0) m_mode = M_ERR;
        else if (!cz) begin
          m_jump  = 1'b1;
          m_jaddr = m_stk[$];
        end else void'(m_stk.pop_back());
      end
    end else if (acc && m_mode == M_SKIP) begin
      if (op_o) begin
        if (m_nest == NEST_MAX) m_mode = M_ERR;
        else m_nest++;
      end else if (op_c) begin
        if (m_nest > 0) m_nest--;
        else m_mode = M_RUN;
      end
    end

    @(posedge clk);
    #1;
    checkOutput("jump", {31'd0, bus.jump}, {31'd0, m_jump});
    if (m_jump || r) checkOutput("jump_addr", {24'd0, bus.jump_addr}, {24'd0, m_jaddr});
    checkOutput("depth", {29'd0, bus.depth}, m_stk.size());
    checkOutput("skipping", {31'd0, bus.skipping}, {31'd0, m_mode == M_SKIP});
    checkOutput("err", {31'd0, bus.err}, {31'd0, m_mode == M_ERR});
  endtask

  initial begin
    logic          rr, vv, oo, cc, zz;
    logic [PW-1:0] pp;
    int            kind;
    bus.op_valid  = 1'b0;
    bus.op_open   = 1'b0;
    bus.op_close  = 1'b0;
    bus.pc        = '0;
    bus.cell_zero = 1'b0;

    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    // Simple loop: push 4, jump back to 4, then exit with a pop.
    applyStimulus(0, 1, 1, 0, 8'd3, 0);
    applyStimulus(0, 1, 0, 1, 8'd9, 0);
    applyStimulus(0, 1, 0, 1, 8'd9, 1);
    // Back-to-back open/close reads the freshly pushed top.
    applyStimulus(0, 1, 1, 0, 8'd10, 0);
    applyStimulus(0, 1, 0, 1, 8'd11, 0);
    applyStimulus(0, 1, 0, 1, 8'd11, 1);
    // Return address wraps at the top of the address space.
    applyStimulus(0, 1, 1, 0, 8'd255, 0);
    applyStimulus(0, 1, 0, 1, 8'd20, 0);
    applyStimulus(0, 1, 0, 1, 8'd20, 1);
    // Nested skip over [ [ ] ].
    applyStimulus(0, 1, 1, 0, 8'd2, 1);
    applyStimulus(0, 1, 1, 0, 8'd3, 0);
    applyStimulus(0, 1, 0, 1, 8'd4, 0);
    applyStimulus(0, 1, 0, 1, 8'd5, 1);
    applyStimulus(0, 0, 1, 0, 8'd6, 0);
    applyStimulus(0, 1, 1, 1, 8'd6, 0);
    applyStimulus(0, 1, 0, 0, 8'd7, 0);
    // Reset mid-skip with nest 3, then a normal push.
    applyStimulus(0, 1, 1, 0, 8'd30, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'd31, 0);
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    applyStimulus(0, 1, 1, 0, 8'd40, 0);
    // Reset on the edge that would launch a jump.
    applyStimulus(0, 1, 0, 1, 8'd45, 0);
    applyStimulus(0, 1, 0, 1, 8'd46, 0);
    applyStimulus(1, 1, 0, 1, 8'd46, 0);
    // Underflow, then nothing is accepted.
    applyStimulus(0, 1, 0, 1, 8'd50, 1);
    applyStimulus(0, 1, 1, 0, 8'd51, 0);
    // Overflow after filling the stack.
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < STACK_MAX + 1; i++) applyStimulus(0, 1, 1, 0, 8'(60 + i), 0);
    applyStimulus(0, 1, 0, 1, 8'd70, 1);
    // Skip nest counter overflow.
    applyStimulus(1, 0, 0, 0, 8'd0, 0);
    applyStimulus(0, 1, 1, 0, 8'd80, 1);
    for (int i = 0; i < NEST_MAX + 1; i++) applyStimulus(0, 1, 1, 0, 8'(81 + i), 0);
    applyStimulus(1, 0, 0, 0, 8'd0, 0);

    for (int n = 0; n < 600; n++) begin
      rr   = ($urandom_range(0, 99) < 3);
      vv   = ($urandom_range(0, 99) >= 12);
      kind = $urandom_range(0, 19);
      oo   = (kind == 0) || (kind >= 3 && kind <= 11);
      cc   = (kind == 0) || (kind >= 12);
      pp   = 8'($urandom_range(0, 255));
      zz   = ($urandom_range(0, 2) == 0);
      applyStimulus(rr, vv, oo, cc, pp, zz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
